data_mem_responder: RTL and testbench

//   Memory-side responder for the CPU data port: services one load/store

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU data port (master) and the memory responder (slave).
// One valid/ready handshake carries the request and a second one returns the response.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a valid/ready handshake, with a programmable number of
// wait states between request accept and the single access that produces the response.
module data_mem_responder #(
    parameter int          DEPTH     = 64,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               do_access;
    logic               acc_we;
    logic               acc_err;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [31:0]        acc_off;
    logic [IDX_W-1:0]   acc_idx;

    assign accept = bus.req_valid && bus.req_ready;

    // With zero wait states the access happens on the accept edge, so it must use the live bus fields.
    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end
    end

    // A wrapped subtraction (addr below base) is caught by the explicit compare, never by the index.
    assign acc_off   = acc_addr - BASE_ADDR;
    assign acc_idx   = acc_off[IDX_W+1:2];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR)
                       || ((acc_off >> 2) >= 32'(DEPTH));
    assign do_access = (next_state == RESP) && (state != RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && reset;
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state == IDLE) && accept) begin
                cap_we    <= bus.req_we;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cnt       <= CNT_LOAD;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                err_q   <= acc_err;
                rdata_q <= (!acc_err && !acc_we) ? mem[acc_idx] : '0;
            end else if ((state == RESP) && bus.rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // RAM contents survive reset; a store only lands when its access actually commits.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (different latency/base) checked every cycle
// against a transaction-level model, plus directed transactions with literal expectations.
module tb_data_mem_responder;
    localparam int          DEPTH = 64;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 0;
    localparam int          LAT2  = 1;
    localparam logic [31:0] BASE2 = 32'h0000_1000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  req_valid = '0;
    logic [2:0]  req_we    = '0;
    logic [2:0]  rsp_ready = '0;
    logic [31:0] req_addr  [3] = '{default: '0};
    logic [31:0] req_wdata [3] = '{default: '0};
    wire  [2:0]  req_ready;
    wire  [2:0]  rsp_valid;
    wire  [2:0]  rsp_err;
    wire  [31:0] rsp_rdata [3];

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    assign bus0.req_valid = req_valid[0];
    assign bus0.req_we    = req_we[0];
    assign bus0.req_addr  = req_addr[0];
    assign bus0.req_wdata = req_wdata[0];
    assign bus0.rsp_ready = rsp_ready[0];
    assign req_ready[0]   = bus0.req_ready;
    assign rsp_valid[0]   = bus0.rsp_valid;
    assign rsp_err[0]     = bus0.rsp_err;
    assign rsp_rdata[0]   = bus0.rsp_rdata;

    assign bus1.req_valid = req_valid[1];
    assign bus1.req_we    = req_we[1];
    assign bus1.req_addr  = req_addr[1];
    assign bus1.req_wdata = req_wdata[1];
    assign bus1.rsp_ready = rsp_ready[1];
    assign req_ready[1]   = bus1.req_ready;
    assign rsp_valid[1]   = bus1.rsp_valid;
    assign rsp_err[1]     = bus1.rsp_err;
    assign rsp_rdata[1]   = bus1.rsp_rdata;

    assign bus2.req_valid = req_valid[2];
    assign bus2.req_we    = req_we[2];
    assign bus2.req_addr  = req_addr[2];
    assign bus2.req_wdata = req_wdata[2];
    assign bus2.rsp_ready = rsp_ready[2];
    assign req_ready[2]   = bus2.req_ready;
    assign rsp_valid[2]   = bus2.rsp_valid;
    assign rsp_err[2]     = bus2.rsp_err;
    assign rsp_rdata[2]   = bus2.rsp_rdata;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT2), .BASE_ADDR(BASE2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    int total  = 0;
    int passed = 0;

    // Model state: one outstanding request per instance, response value decided at its due edge.
    logic [31:0] mMem   [3][DEPTH];
    bit          mPend  [3] = '{default: 1'b0};
    bit          mRv    [3] = '{default: 1'b0};
    bit          mEr    [3] = '{default: 1'b0};
    logic [31:0] mRd    [3] = '{default: '0};
    bit          mWe    [3] = '{default: 1'b0};
    logic [31:0] mAddr  [3] = '{default: '0};
    logic [31:0] mWdata [3] = '{default: '0};
    longint      mDue   [3] = '{default: 0};
    longint      cyc = 0;

    function automatic int latOf(int i);
        return (i == 0) ? LAT0 : (i == 1) ? LAT1 : LAT2;
    endfunction

    function automatic logic [31:0] baseOf(int i);
        return (i == 2) ? BASE2 : 32'h0;
    endfunction

    function automatic void modelAccess(int i);
        longint off;
        bit     err;
        off = longint'(mAddr[i]) - longint'(baseOf(i));
        err = (mAddr[i] % 4 != 0) || (off < 0) || (off >= DEPTH * 4);
        mRv[i] = 1'b1;
        mEr[i] = err;
        mRd[i] = '0;
        if (!err) begin
            if (mWe[i]) mMem[i][int'(off / 4)] = mWdata[i];
            else        mRd[i] = mMem[i][int'(off / 4)];
        end
    endfunction

    // Request captured at edge c is accessed at edge c+LATENCY, visible from then until handshake.
    function automatic void modelStep(int i);
        if (!reset) begin
            mPend[i] = 1'b0; mRv[i] = 1'b0; mEr[i] = 1'b0; mRd[i] = '0;
        end else if (mRv[i]) begin
            if (rsp_ready[i]) begin
                mPend[i] = 1'b0; mRv[i] = 1'b0; mEr[i] = 1'b0; mRd[i] = '0;
            end
        end else if (mPend[i]) begin
            if (cyc == mDue[i]) modelAccess(i);
        end else if (req_valid[i]) begin
            mWe[i]    = req_we[i];
            mAddr[i]  = req_addr[i];
            mWdata[i] = req_wdata[i];
            mPend[i]  = 1'b1;
            mDue[i]   = cyc + latOf(i);
            if (latOf(i) == 0) modelAccess(i);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) modelStep(i);
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s[%0d] t=%0t: got %h, expected %h", name, inst, $time, act, exp);
        else
            passed++;
    endtask

    bit checkEn = 1'b1;
    always @(negedge clk) begin
        if (checkEn) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("model_req_ready", i, 32'(req_ready[i]), 32'(reset && !mPend[i]));
                checkOutput("model_rsp_valid", i, 32'(rsp_valid[i]), 32'(reset && mRv[i]));
                checkOutput("model_rsp_err",   i, 32'(rsp_err[i]),   32'(reset && mEr[i]));
                checkOutput("model_rsp_rdata", i, rsp_rdata[i],      reset ? mRd[i] : 32'h0);
            end
        end
    end

    task automatic applyStimulus(input int i, input bit v, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[i] = v;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
    endtask

    // Presents a request, waits for accept and response, holds rsp_ready low for 'stall' cycles.
    task automatic doTxn(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, input logic [31:0] expRd, input bit expErr, input int expLat);
        bit acc;
        int lat;
        applyStimulus(i, 1'b1, we, addr, wdata);
        acc = 1'b0;
        lat = 0;
        while (!acc && lat < 50) begin
            acc = req_ready[i];
            @(posedge clk); #1;
            lat++;
        end
        applyStimulus(i, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!acc) checkOutput("accept_timeout", i, 32'd0, 32'd1);
        while (!rsp_valid[i] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("rsp_latency", i, 32'(lat), 32'(expLat));
        checkOutput("rsp_rdata",   i, rsp_rdata[i], expRd);
        checkOutput("rsp_err",     i, 32'(rsp_err[i]), 32'(expErr));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", i, 32'(rsp_valid[i]), 32'd1);
            checkOutput("hold_rdata", i, rsp_rdata[i], expRd);
            checkOutput("hold_err",   i, 32'(rsp_err[i]), 32'(expErr));
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_req_ready", i, 32'(req_ready[i]), 32'd0);
            checkOutput("reset_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            checkOutput("reset_rsp_rdata", i, rsp_rdata[i], 32'h0);
            checkOutput("reset_rsp_err",   i, 32'(rsp_err[i]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Instance 0: LATENCY=2, base 0
        doTxn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 3);
        doTxn(0, 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 3);
        doTxn(0, 1'b1, 32'h00, 32'h1111_1111, 0, 32'h0, 1'b0, 3);
        doTxn(0, 1'b1, 32'h08, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 3);
        doTxn(0, 1'b1, 32'h20, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 3);

        doTxn(0, 1'b0, 32'h12,  32'h0, 0, 32'h0, 1'b1, 3);
        doTxn(0, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b1, 3);
        doTxn(0, 1'b1, 32'h102, 32'h5555_5555, 0, 32'h0, 1'b1, 3);
        doTxn(0, 1'b1, 32'h100, 32'h9999_9999, 0, 32'h0, 1'b1, 3);
        doTxn(0, 1'b0, 32'h00,  32'h0, 0, 32'h1111_1111, 1'b0, 3);
        doTxn(0, 1'b0, 32'h10,  32'h0, 0, 32'hDEAD_BEEF, 1'b0, 3);

        doTxn(0, 1'b0, 32'h08, 32'h0, 5, 32'h0BAD_F00D, 1'b0, 3);
        checkOutput("ready_after_rsp", 0, 32'(req_ready[0]), 32'd1);
        checkOutput("valid_after_rsp", 0, 32'(rsp_valid[0]), 32'd0);

        // Reset while a store sits in its wait states: the store must never land.
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("rst_pulse_valid", 0, 32'(rsp_valid[0]), 32'd0);
        checkOutput("rst_pulse_ready", 0, 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_release_ready", 0, 32'(req_ready[0]), 32'd1);
        doTxn(0, 1'b0, 32'h20, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 3);

        // Instance 1: LATENCY=0, back-to-back loads with req_valid held
        doTxn(1, 1'b1, 32'h0, 32'hAAAA_0000, 0, 32'h0, 1'b0, 1);
        doTxn(1, 1'b1, 32'h4, 32'hBBBB_1111, 0, 32'h0, 1'b0, 1);
        rsp_ready[1] = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checkOutput("b2b_valid_a", 1, 32'(rsp_valid[1]), 32'd1);
        checkOutput("b2b_rdata_a", 1, rsp_rdata[1], 32'hAAAA_0000);
        checkOutput("b2b_ready_a", 1, 32'(req_ready[1]), 32'd0);
        req_addr[1] = 32'h4;
        @(posedge clk); #1;
        checkOutput("b2b_gap_valid", 1, 32'(rsp_valid[1]), 32'd0);
        checkOutput("b2b_gap_ready", 1, 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        checkOutput("b2b_valid_b", 1, 32'(rsp_valid[1]), 32'd1);
        checkOutput("b2b_rdata_b", 1, rsp_rdata[1], 32'hBBBB_1111);
        checkOutput("b2b_ready_b", 1, 32'(req_ready[1]), 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checkOutput("b2b_end_valid", 1, 32'(rsp_valid[1]), 32'd0);
        checkOutput("b2b_end_ready", 1, 32'(req_ready[1]), 32'd1);
        rsp_ready[1] = 1'b0;

        // Instance 2: LATENCY=1, base 0x1000
        doTxn(2, 1'b0, 32'h0FFC, 32'h0, 0, 32'h0, 1'b1, 2);
        doTxn(2, 1'b0, 32'h0000, 32'h0, 0, 32'h0, 1'b1, 2);
        doTxn(2, 1'b1, 32'h1000, 32'hA5A5_5A5A, 0, 32'h0, 1'b0, 2);
        doTxn(2, 1'b0, 32'h1000, 32'h0, 0, 32'hA5A5_5A5A, 1'b0, 2);
        doTxn(2, 1'b1, 32'h10FC, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, 2);
        doTxn(2, 1'b0, 32'h10FC, 32'h0, 0, 32'h0F0F_0F0F, 1'b0, 2);
        doTxn(2, 1'b0, 32'h1100, 32'h0, 0, 32'h0, 1'b1, 2);
        doTxn(2, 1'b0, 32'h1000, 32'h0, 0, 32'hA5A5_5A5A, 1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
